// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cam_pkg
// Brief    : Shared constants, FSM state encoding and queue entry layout for
//            the CAM write queue.
// Revision : 1.0
// ============================================================================
package cam_pkg;

    localparam int DATA_PER_BLOCK     = 7;
    localparam int CAM_DEF_ADDR_WIDTH = 5;
    localparam int CAM_DEF_DATA_WIDTH = 5 * DATA_PER_BLOCK;

    typedef enum logic [2:0] {
        INIT      = 3'd0,
        IDLE      = 3'd1,
        ISSUE     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4
    } cam_wq_state_t;

    // Layout for the default geometry; the top re-declares it at its own widths.
    typedef struct packed {
        logic [CAM_DEF_ADDR_WIDTH-1:0] addr;
        logic [CAM_DEF_DATA_WIDTH-1:0] data;
        logic [CAM_DEF_DATA_WIDTH-1:0] care;
    } cam_wq_entry_t;

endpackage
`default_nettype wire

// File: rtl/cam_wq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cam_wq_fifo
// Brief    : Synchronous show-ahead FIFO holding pending CAM write requests.
// Revision : 1.0
// ============================================================================
module cam_wq_fifo
    import cam_pkg::*;
#(
    parameter int  FIFO_AW = 2,
    parameter type ENTRY_T = cam_wq_entry_t
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  ENTRY_T           push_data,
    input  logic             pop,
    output ENTRY_T           head,
    output logic             empty,
    output logic             full,
    output logic [FIFO_AW:0] level
);

    localparam int c_depth = 2 ** FIFO_AW;

    ENTRY_T           r_mem [c_depth];
    logic [FIFO_AW:0] r_wr_ptr;
    logic [FIFO_AW:0] r_rd_ptr;

    // Extra MSB on each pointer distinguishes full from empty.
    assign level = r_wr_ptr - r_rd_ptr;
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                   (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    assign head  = r_mem[r_rd_ptr[FIFO_AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + (FIFO_AW+1)'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + (FIFO_AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr[FIFO_AW-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/cam_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : cam_write_queue
// Brief    : Queues CAM write requests and issues them one at a time through
//            the CAM write-port handshake. Define CAM_WQ_SHADOW_EN to keep a
//            bitmap of completed writes on entry_written.
// Revision : 1.0
// ============================================================================
module cam_write_queue
    import cam_pkg::*;
#(
    parameter  int DATA_BLOCKS = 5,
    parameter  int ADDR_WIDTH  = 5,
    parameter  int FIFO_AW     = 2,
    parameter  int ARM_LIMIT   = 4,
    localparam int DATA_WIDTH  = DATA_PER_BLOCK * DATA_BLOCKS,
    localparam int WORDS       = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [DATA_WIDTH-1:0] in_care,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] wcare,
    output logic                  start_write,
    input  logic                  cam_ready,
    output logic                  busy,
    output logic [FIFO_AW:0]      level,
    output logic                  arm_err,
    output logic [WORDS-1:0]      entry_written
);

    localparam int c_cnt_w = $clog2(ARM_LIMIT + 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [DATA_WIDTH-1:0] care;
    } entry_t;

    cam_wq_state_t         r_state;
    logic [c_cnt_w-1:0]    r_arm_cnt;
    logic                  r_start_write;
    logic                  r_arm_err;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_wcare;

    entry_t w_push_entry;
    entry_t w_head;
    logic   w_push;
    logic   w_pop;
    logic   w_empty;
    logic   w_full;

    assign w_push_entry = '{addr: in_addr, data: in_data, care: in_care};
    assign in_ready     = !w_full;
    assign w_push       = in_valid && !w_full;
    assign w_pop        = (r_state == IDLE) && !w_empty && cam_ready;

    cam_wq_fifo #(
        .FIFO_AW (FIFO_AW),
        .ENTRY_T (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .head      (w_head),
        .empty     (w_empty),
        .full      (w_full),
        .level     (level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= INIT;
            r_arm_cnt     <= '0;
            r_start_write <= 1'b0;
            r_arm_err     <= 1'b0;
            r_waddr       <= '0;
            r_wdata       <= '0;
            r_wcare       <= '0;
        end else begin
            r_start_write <= 1'b0;
            case (r_state)
                INIT: begin
                    if (cam_ready) r_state <= IDLE;
                end
                IDLE: begin
                    if (w_pop) begin
                        r_waddr       <= w_head.addr;
                        r_wdata       <= w_head.data;
                        r_wcare       <= w_head.care;
                        r_start_write <= 1'b1;
                        r_state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_arm_cnt <= '0;
                    r_state   <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // A CAM that never acknowledges is flagged and skipped
                    // so the rest of the queue still drains.
                    if (!cam_ready) begin
                        r_state <= WAIT_DONE;
                    end else if (r_arm_cnt == c_cnt_w'(ARM_LIMIT - 1)) begin
                        r_arm_err <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_arm_cnt <= r_arm_cnt + c_cnt_w'(1);
                    end
                end
                WAIT_DONE: begin
                    if (cam_ready) r_state <= IDLE;
                end
                default: r_state <= INIT;
            endcase
        end
    end

    assign start_write = r_start_write;
    assign arm_err     = r_arm_err;
    assign waddr       = r_waddr;
    assign wdata       = r_wdata;
    assign wcare       = r_wcare;
    assign busy        = !w_empty || (r_state != IDLE);

`ifdef CAM_WQ_SHADOW_EN
    logic [WORDS-1:0] r_entry_written;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_entry_written <= '0;
        end else if ((r_state == WAIT_DONE) && cam_ready) begin
            r_entry_written[r_waddr] <= 1'b1;
        end
    end

    assign entry_written = r_entry_written;
`else
    assign entry_written = '0;
`endif

endmodule
`default_nettype wire
